// File: rtl/mp_add_sequencer.sv
// rtl/mp_add_sequencer.sv - multi-word add/sub sequencer feeding an external adder core
module mp_add_sequencer #(
  parameter int WIDTH     = 64,
  parameter int MAX_WORDS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  input  logic             in_last,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_last,
  output logic             out_cout,
  output logic             out_err
);

  // Counter must reach MAX_WORDS-1; keep at least one bit for degenerate sizes.
  localparam int CW = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_WORDS - 1);

  typedef enum logic {
    ST_FIRST = 1'b0,
    ST_CHAIN = 1'b1
  } state_t;

  state_t        state;
  logic          sub_q;
  logic          carry_q;
  logic [CW-1:0] word_cnt;

  logic          sub_eff;
  logic          accept;
  logic          cnt_end;
  logic          op_end;

  // Operand steering to the adder core and handshake/termination decode.
  always_comb begin
    sub_eff  = 1'b0;
    add_cin  = 1'b0;
    in_ready = !out_valid || out_ready;
    accept   = in_valid && in_ready;
    cnt_end  = (word_cnt == CNT_LAST);
    op_end   = in_last || cnt_end;
    if (state == ST_FIRST) begin
      // Subtract needs the +1 of two's complement on the least-significant word.
      sub_eff = in_sub;
      add_cin = in_cin | in_sub;
    end else begin
      sub_eff = sub_q;
      add_cin = carry_q;
    end
    add_a = in_a;
    add_b = in_b ^ {WIDTH{sub_eff}};
  end

  // Sequencer state, carry chain and the one-entry registered output stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_FIRST;
      sub_q     <= 1'b0;
      carry_q   <= 1'b0;
      word_cnt  <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_last  <= 1'b0;
      out_cout  <= 1'b0;
      out_err   <= 1'b0;
    end else if (accept) begin
      out_sum   <= add_sum;
      carry_q   <= add_cout;
      out_valid <= 1'b1;
      out_last  <= op_end;
      out_err   <= cnt_end && !in_last;
      if (op_end) begin
        out_cout <= add_cout;
        word_cnt <= '0;
      end else begin
        word_cnt <= word_cnt + CW'(1);
      end
      case (state)
        ST_FIRST: begin
          sub_q <= in_sub;
          if (!op_end) begin
            state <= ST_CHAIN;
          end
        end
        ST_CHAIN: begin
          if (op_end) begin
            state <= ST_FIRST;
          end
        end
        default: state <= ST_FIRST;
      endcase
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
